// File: rtl/dark_mixer.sv
// Dark-mode pixel mixer: blends each RGB channel between x and 255-x by a per-frame alpha.
// Build option DARK_MIXER_FADE_EN: gradual fade over 2**FADE_LOG2 frames; otherwise instant switch.
module dark_mixer #(
   parameter int FADE_LOG2 = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic                 vs_i,
   input  logic                 hs_i,
   input  logic                 de_i,
   input  logic [7:0]           r_i,
   input  logic [7:0]           g_i,
   input  logic [7:0]           b_i,
   output logic                 vs_o,
   output logic                 hs_o,
   output logic                 de_o,
   output logic [7:0]           r_o,
   output logic [7:0]           g_o,
   output logic [7:0]           b_o,
   output logic [FADE_LOG2:0]   alpha_o
);
   localparam int AW = FADE_LOG2 + 1;
   localparam int PW = 8 + FADE_LOG2;
   localparam int SW = PW + 1;
   localparam logic [AW-1:0] ALPHA_MAX = AW'(1 << FADE_LOG2);

   function automatic logic [PW-1:0] scale(input logic [7:0] x, input logic [AW-1:0] k);
      return PW'({{(PW-8){1'b0}}, x} * {{(PW-AW){1'b0}}, k});
   endfunction

   // The two weights always sum to F, so the shifted sum never exceeds 255.
   function automatic logic [7:0] blend(input logic [PW-1:0] a, input logic [PW-1:0] b);
      logic [SW-1:0] sum;
      sum = SW'(a) + SW'(b);
      return 8'(sum >> FADE_LOG2);
   endfunction

   logic            vs_q, vs_d;
   logic            bnd_q, bnd_d;
   logic [AW-1:0]   alpha_q, alpha_d;

   logic [2:0][7:0]    pix_in;
   logic [2:0][PW-1:0] pos_p1_q, pos_p1_d;
   logic [2:0][PW-1:0] neg_p1_q, neg_p1_d;
   logic [2:0]         sync_p1_q, sync_p1_d;
   logic [2:0][7:0]    pix_p2_q, pix_p2_d;
   logic [2:0]         sync_p2_q, sync_p2_d;

   assign pix_in = {r_i, g_i, b_i};

   // Boundary detected in cycle T is latched, so rx_i is taken in T+1 once upstream has frozen it.
   always_comb begin
      vs_d    = vs_i;
      bnd_d   = vs_q & ~vs_i;
      alpha_d = alpha_q;
      if (bnd_q) begin
`ifdef DARK_MIXER_FADE_EN
         if (rx_i) begin
            if (alpha_q != ALPHA_MAX) alpha_d = alpha_q + AW'(1);
         end else begin
            if (alpha_q != '0) alpha_d = alpha_q - AW'(1);
         end
`else
         alpha_d = rx_i ? ALPHA_MAX : '0;
`endif
      end
   end

   always_comb begin
      // Stage 1: weighted products for the normal and inverted pixel
      for (int c = 0; c < 3; c++) begin
         pos_p1_d[c] = scale(pix_in[c], ALPHA_MAX - alpha_q);
         neg_p1_d[c] = scale(~pix_in[c], alpha_q);
      end
      sync_p1_d = {vs_i, hs_i, de_i};
      // Stage 2: sum and normalise
      for (int c = 0; c < 3; c++) begin
         pix_p2_d[c] = blend(pos_p1_q[c], neg_p1_q[c]);
      end
      sync_p2_d = sync_p1_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_q      <= 1'b0;
         bnd_q     <= 1'b0;
         alpha_q   <= '0;
         pos_p1_q  <= '0;
         neg_p1_q  <= '0;
         sync_p1_q <= '0;
         pix_p2_q  <= '0;
         sync_p2_q <= '0;
      end else begin
         vs_q      <= vs_d;
         bnd_q     <= bnd_d;
         alpha_q   <= alpha_d;
         pos_p1_q  <= pos_p1_d;
         neg_p1_q  <= neg_p1_d;
         sync_p1_q <= sync_p1_d;
         pix_p2_q  <= pix_p2_d;
         sync_p2_q <= sync_p2_d;
      end
   end

   assign {vs_o, hs_o, de_o} = sync_p2_q;
   assign {r_o, g_o, b_o}    = pix_p2_q;
   assign alpha_o            = alpha_q;

endmodule

// File: tb/tb_dark_mixer.sv
// Scoreboard bench for dark_mixer; expectations follow DARK_MIXER_FADE_EN when it is defined.
module tb_dark_mixer;
   localparam int FADE_LOG2 = 3;
   localparam int F = 1 << FADE_LOG2;
   localparam int FL = 24;

   logic clk = 1'b0;
   logic rst_i = 1'b1, rx_i = 1'b0, vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
   logic [7:0] r_i = '0, g_i = '0, b_i = '0;
   logic vs_o, hs_o, de_o;
   logic [7:0] r_o, g_o, b_o;
   logic [FADE_LOG2:0] alpha_o;

   dark_mixer #(.FADE_LOG2(FADE_LOG2)) dut (
      .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
      .r_i(r_i), .g_i(g_i), .b_i(b_i), .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o),
      .r_o(r_o), .g_o(g_o), .b_o(b_o), .alpha_o(alpha_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [26:0] data;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   logic m_vs = 1'b0, m_bnd = 1'b0, bnd_prev;
   logic [FADE_LOG2:0] m_alpha = '0;

   function automatic logic [7:0] mix(input logic [7:0] x, input logic [FADE_LOG2:0] a);
      int xi, ai;
      xi = int'(x);
      ai = int'(a);
      return 8'((xi * (F - ai) + (255 - xi) * ai) / F);
   endfunction

   function automatic logic [2:0] fsync(input int i);
      return {i < 2, (i % 8) == 0, (i >= 3) && ((i % 8) >= 2)};
   endfunction

   // Drive one cycle at the falling edge, record expectations, advance the reference model.
   task automatic tick(input logic rst, input logic rx, input logic [2:0] s,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      exp_t n;
      rst_i = rst; rx_i = rx; {vs_i, hs_i, de_i} = s; r_i = r; g_i = g; b_i = b;
      @(posedge clk);
      cyc++;
      if (rst) begin
         q.delete();
         n.due = cyc;     n.data = '0; q.push_back(n);
         n.due = cyc + 1; n.data = '0; q.push_back(n);
         m_vs = 1'b0; m_bnd = 1'b0; m_alpha = '0;
      end else begin
         n.due  = cyc + 1;
         n.data = {s, mix(r, m_alpha), mix(g, m_alpha), mix(b, m_alpha)};
         q.push_back(n);
         bnd_prev = m_bnd;
         m_bnd = m_vs & ~s[2];
         m_vs  = s[2];
         if (bnd_prev) begin
`ifdef DARK_MIXER_FADE_EN
            if (rx) begin
               if (m_alpha < F) m_alpha++;
            end else begin
               if (m_alpha > 0) m_alpha--;
            end
`else
            m_alpha = rx ? (FADE_LOG2+1)'(F) : '0;
`endif
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         tick(i < 2, 1'b0, 3'b000, 8'h12, 8'h34, 8'h56);
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front(); checks++;
            if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
               failures++; $display("FAIL reset_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
            end
         end
         checks++;
         if (alpha_o !== '0) begin failures++; $display("FAIL reset_alpha got=%0d want=0", alpha_o); end
      end
   endtask

   task automatic test_normal();
      for (int i = 0; i < 3 * FL; i++) begin
         tick(1'b0, 1'b0, fsync(i % FL), 8'h40, 8'h40, 8'h40);
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front(); checks++;
            if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
               failures++; $display("FAIL normal_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
            end
         end
      end
      checks++;
      if ({r_o, g_o, b_o, alpha_o} !== {24'h404040, 4'd0}) begin
         failures++; $display("FAIL normal_const got=%h_%0d want=404040_0", {r_o, g_o, b_o}, alpha_o);
      end
   endtask

   task automatic test_fade();
      for (int i = 0; i < 10 * FL; i++) begin
         tick(1'b0, 1'b1, fsync(i % FL), 8'h00, 8'h40, 8'($urandom));
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front(); checks++;
            if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
               failures++; $display("FAIL fade_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
            end
         end
         checks++;
         if (alpha_o !== m_alpha) begin failures++; $display("FAIL fade_alpha got=%0d want=%0d", alpha_o, m_alpha); end
      end
      checks++;
      if ({alpha_o, r_o, g_o} !== {4'(F), 8'hFF, 8'hBF}) begin
         failures++; $display("FAIL fade_sat got=%0d_%h_%h want=%0d_ff_bf", alpha_o, r_o, g_o, F);
      end
   endtask

   task automatic test_reversal();
      tick(1'b1, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 8 * FL; i++) begin
         tick(1'b0, (i < 3 * FL), fsync(i % FL), 8'h80, 8'($urandom), 8'h7F);
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front(); checks++;
            if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
               failures++; $display("FAIL reversal_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
            end
         end
         checks++;
         if (alpha_o !== m_alpha) begin failures++; $display("FAIL reversal_alpha got=%0d want=%0d", alpha_o, m_alpha); end
      end
      checks++;
      if (alpha_o !== '0) begin failures++; $display("FAIL reversal_end got=%0d want=0", alpha_o); end
   endtask

   // rx disagrees with the T+1 value everywhere else in the frame
   task automatic test_rx_sample();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < FL; i++) begin
            tick(1'b0, (i == 3) ? f[0] : ~f[0], fsync(i), 8'($urandom), 8'($urandom), 8'($urandom));
            while (q.size() > 0 && q[0].due == cyc) begin
               e = q.pop_front(); checks++;
               if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
                  failures++; $display("FAIL rxsample_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
               end
            end
            checks++;
            if (alpha_o !== m_alpha) begin failures++; $display("FAIL rxsample_alpha got=%0d want=%0d", alpha_o, m_alpha); end
         end
      end
      checks++;
`ifdef DARK_MIXER_FADE_EN
      if (alpha_o !== 4'd1) begin failures++; $display("FAIL rxsample_end got=%0d want=1", alpha_o); end
`else
      if (alpha_o !== 4'(F)) begin failures++; $display("FAIL rxsample_end got=%0d want=%0d", alpha_o, F); end
`endif
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 9 * FL; i++) begin
         tick(i == 6 * FL + 10, (i < 6 * FL), fsync(i % FL), 8'($urandom), 8'($urandom), 8'($urandom));
         if (i == 6 * FL + 10) begin
            checks++;
            if ({alpha_o, r_o, g_o, b_o} !== 28'd0) begin
               failures++; $display("FAIL midreset_zero got=%0d_%h want=0_000000", alpha_o, {r_o, g_o, b_o});
            end
         end
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front(); checks++;
            if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
               failures++; $display("FAIL midreset_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
            end
         end
         checks++;
         if (alpha_o !== m_alpha) begin failures++; $display("FAIL midreset_alpha got=%0d want=%0d", alpha_o, m_alpha); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         tick(1'b0, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front(); checks++;
            if ({vs_o, hs_o, de_o, r_o, g_o, b_o} !== e.data) begin
               failures++; $display("FAIL b2b_out cyc=%0d got=%h want=%h", cyc, {vs_o, hs_o, de_o, r_o, g_o, b_o}, e.data);
            end
         end
         checks++;
         if (alpha_o !== m_alpha) begin failures++; $display("FAIL b2b_alpha got=%0d want=%0d", alpha_o, m_alpha); end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_fade();
      test_reversal();
      test_rx_sample();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dark_mixer.md
Name: dark_mixer

Overview:
- Downstream of the frame dark/bright decision stage. Consumes its per-frame `rx_i` decision and the raw RGB pixel stream.
- Outputs RGB that is normal, fully inverted (255−x), or a linear crossfade between the two.
- The crossfade advances one step per frame, so the display fades rather than flashes when the decision flips.
- Sync signals are delayed to match the pixel pipeline. Feeds the TMDS/output encoder.

Parameters:
- FADE_LOG2, 3, log2 of number of fade steps; F = 2**FADE_LOG2 frames for a full transition (legal 1..6).

Ports:
- clk_i  in  1  pixel clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- rx_i  in  1  frame decision from the upstream stage; 1 = bright frame, render dark
- vs_i  in  1  vertical sync
- hs_i  in  1  horizontal sync
- de_i  in  1  data enable
- r_i, g_i, b_i  in  8 each  input pixel channels
- vs_o, hs_o, de_o  out  1 each  sync/enable delayed by 2 cycles
- r_o, g_o, b_o  out  8 each  mixed pixel channels, 2-cycle latency
- alpha_o  out  FADE_LOG2+1  current mix factor, 0..F (debug/status)

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - alpha=0, state LIGHT, vs edge register=0.
  - All pipeline registers and outputs = 0.
  - Reset mid-frame discards in-flight pixels; outputs stay 0 until 2 cycles after rst_i deasserts.
- Frame boundary:
  - vs_q is vs_i registered. A boundary is the falling edge: vs_q=1 && vs_i=0 in cycle T.
  - rx_i is sampled in cycle T+1; alpha updates at the end of T+1.
  - The one-cycle delay guarantees the upstream stage's freshly frozen decision is the one seen.
  - alpha never changes at any other time.
- States, derived from alpha and target:
  - LIGHT (alpha=0)
  - TO_DARK (0<alpha<F, target 1)
  - DARK (alpha=F)
  - TO_LIGHT (0<alpha<F, target 0)
- Update at each boundary:
  - rx=1: alpha = min(alpha+1, F)
  - rx=0: alpha = max(alpha−1, 0)
  - A reversal mid-fade simply changes direction from the current alpha; no restart, no skipped steps.
  - Saturates at 0 and F with no wrap.
- Mix per channel x: y = (x·(F−alpha) + (255−x)·alpha) >> FADE_LOG2, truncating.
  - Each product is 8+FADE_LOG2 bits unsigned; the sum is 8+FADE_LOG2+1 bits.
  - Result is always ≤255; no clamp needed.
  - alpha=0 gives y=x exactly; alpha=F gives y=255−x exactly.
- Pipeline:
  - Stage 1 registers both products per channel plus a snapshot of alpha.
  - Stage 2 registers the sum and shift.
  - vs/hs/de pass through two matching registers.
  - Latency is exactly 2 cycles for all outputs; throughput is 1 pixel/cycle with no stalls.
- Pixel values are mixed regardless of de_i; blanking data passes through the same math.
- alpha_o reflects the alpha register directly (0 cycles), not pipeline-aligned.
- A boundary that coincides with the first cycle after reset release is ignored, because vs_q=0 after reset.

Optional Feature:
- Macro DARK_MIXER_FADE_EN.
- Defined: gradual fade exactly as above.
- Undefined: each boundary sets alpha = rx ? F : 0 directly (instant switch).
  - TO_DARK and TO_LIGHT are unreachable.
  - Datapath and latency are unchanged.

Test Plan:
- Reset, then drive r=g=b=0x40, rx=0 for 3 frames -> out 0x40 on all channels, alpha_o=0, out delayed 2 cycles from input, vs_o/hs_o/de_o aligned.
- FADE_LOG2=3, rx=1 held, input r=0x00 -> alpha steps 1..8 over 8 boundaries; r_o = 0x1F,0x3F,0x5F,…,0xDF, then 0xFF; alpha saturates at 8 on boundary 9+.
- Reversal: rx=1 for 3 frames (alpha=3), then rx=0 -> alpha 2,1,0, then stays 0; x=0x80 at alpha=3 gives (0x80·5+0x7F·3)>>3 = 0x7F.
- rx toggled mid-frame (no vs falling edge) -> alpha unchanged until the next boundary; the rx value sampled is the one in cycle T+1.
- rst_i asserted mid-frame at alpha=5 -> next cycle alpha_o=0, outputs 0; 2 cycles after release outputs track input·1 (unmodified).
- Build without DARK_MIXER_FADE_EN, rx 0→1 -> after one boundary alpha_o=F, r_o = 255−r_i; back to 0 after one boundary with rx=0.
